mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
- Two-requester read arbiter sharing the single main-memory read port (arvalid/addr/data/rvalid) between two cache controllers, e.g. instruction and data cache.
- Sits between the cache modules and the main memory module.
- Grants one transaction at a time with round-robin fairness.
- Routes the 64-bit memory line back to the granted requester.
- Has a busy-cycle watchdog that terminates hung transactions with an error response.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, memory line width.
- TIMEOUT, 255, max BUSY cycles to wait for mem_rvalid; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset: synchronous, active-high (1 = reset). The name is kept for codebase consistency; polarity and synchronicity are fixed.
- req0_arvalid  in  1  requester 0 read request (level).
- req0_addr  in  ADDR_W  requester 0 address; stable while req0_arvalid=1.
- req0_arready  out  1  one-cycle accept pulse to requester 0.
- req0_rvalid  out  1  one-cycle response-valid pulse to requester 0.
- req0_err  out  1  qualifies req0_rvalid; 1 = timed out.
- req1_arvalid, req1_addr, req1_arready, req1_rvalid, req1_err: same as requester 0, for requester 1.
- rsp_data  out  DATA_W  response line (shared); valid only with reqN_rvalid.
- mem_arvalid  out  1  request to main memory (level).
- mem_addr  out  ADDR_W  address to main memory.
- mem_data  in  DATA_W  main memory line.
- mem_rvalid  in  1  main memory data valid.
- gnt_id  out  1  requester owning the current transaction (debug).

Behaviour:
- All outputs are registered.
- Reset values: every output is 0; state=IDLE; last_grant=1 (so requester 0 wins the first tie); timeout counter=0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If exactly one reqN_arvalid=1, grant it.
  - If both are 1, grant the requester not equal to last_grant.
  - On grant at edge N+1: reqN_arready=1 for that cycle; mem_addr=reqN_addr as sampled at edge N+1; mem_arvalid=1; gnt_id=N; last_grant=N; counter=0; state=BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - mem_arvalid and mem_addr are held stable. reqN_arready=0. The counter increments each BUSY cycle.
  - mem_rvalid=1 sampled: next cycle state=RESP, rsp_data=mem_data, req[gnt]_rvalid=1, req[gnt]_err=0, mem_arvalid=0.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without mem_rvalid: next cycle state=RESP, rsp_data=0, req[gnt]_rvalid=1, req[gnt]_err=1, mem_arvalid=0.
  - mem_rvalid takes priority over timeout in the same cycle.
- RESP:
  - Lasts one cycle, then IDLE; rvalid/err return to 0.
  - rsp_data holds its value until the next response.
  - Requests cannot be granted in RESP. The earliest back-to-back grant is the cycle after RESP.
- Latency:
  - Request first seen at edge N gives arready at N+1.
  - If mem_rvalid arrives in the first BUSY cycle, rvalid appears at N+2.
  - Minimum issue-to-issue spacing is 3 cycles.
- Requester rules:
  - A requester keeps arvalid/addr stable until it sees arready.
  - It may deassert before grant (the request is withdrawn; no grant is issued).
  - arvalid held after arready counts as a new request.
- mem_rvalid sampled in IDLE or RESP is ignored. No data is routed and no state changes.
- Counter width is $clog2(TIMEOUT+1), minimum 1. It saturates and does not wrap.
- Only one transaction is outstanding. The non-granted requester waits, and round-robin guarantees it the next grant.
- Reset asserted in any state: next cycle all outputs are 0 and state=IDLE. An in-flight memory response is dropped. The requester restarts its request after reset.

Test Plan:
- Reset, then req0_arvalid=1 with addr=0x0000_0040; memory returns 0x1122_3344_5566_7788 two cycles after mem_arvalid rises -> req0_arready pulses once; mem_addr=0x40; req0_rvalid=1, req0_err=0, rsp_data=0x1122334455667788; req1 outputs stay 0.
- Both requesters request continuously (addr0=0x100, addr1=0x200), memory answers at 1 cycle -> grant order 0,1,0,1 with gnt_id alternating; mem_addr alternates 0x100/0x200; each response goes only to its owner; issue spacing is 3 cycles.
- TIMEOUT=4, req1 request and memory never responds -> mem_arvalid high for exactly 4 BUSY cycles; then req1_rvalid=1, req1_err=1, rsp_data=0; arbiter returns to IDLE and accepts a following req0.
- mem_rvalid asserted in the same cycle the counter reaches TIMEOUT-1, with data 0xDEAD_BEEF_0000_0001 -> err=0 and the data is delivered.
- Spurious mem_rvalid pulse in IDLE -> no rvalid and no state change. Separately, req0 raises arvalid for one cycle and withdraws it while req1 is being served -> no grant to req0.
- rst_n=1 asserted mid-BUSY, then memory responds after reset release -> all outputs 0 on the cycle after reset; the late mem_rvalid is ignored in IDLE; no rvalid is issued.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one main-memory read port between two cache controllers.
// One transaction at a time. A busy-cycle watchdog ends hung reads with an error response.
module mem_read_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_arvalid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_arready,
    output logic              req0_rvalid,
    output logic              req0_err,
    input  logic              req1_arvalid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_arready,
    output logic              req1_rvalid,
    output logic              req1_err,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_arvalid,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_rvalid,
    output logic              gnt_id,
    output logic [1:0]        dbg_state
);
    // Handshake: reqN_arvalid is a level held with a stable address until the
    // one-cycle reqN_arready pulse; reqN_rvalid is a one-cycle pulse qualified by reqN_err.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t             state, state_nx;
    logic               last_grant, last_grant_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               pick;
    logic               arready0_nx, arready1_nx, rvalid0_nx, rvalid1_nx, err0_nx, err1_nx;
    logic [DATA_W-1:0]  rsp_data_nx;
    logic               mem_arvalid_nx;
    logic [ADDR_W-1:0]  mem_addr_nx;
    logic               gnt_id_nx;

    assign dbg_state = state;

    always_comb begin
        state_nx       = state;
        last_grant_nx  = last_grant;
        cnt_nx         = cnt;
        pick           = 1'b0;
        arready0_nx    = 1'b0;
        arready1_nx    = 1'b0;
        rvalid0_nx     = 1'b0;
        rvalid1_nx     = 1'b0;
        err0_nx        = 1'b0;
        err1_nx        = 1'b0;
        rsp_data_nx    = rsp_data;
        mem_arvalid_nx = mem_arvalid;
        mem_addr_nx    = mem_addr;
        gnt_id_nx      = gnt_id;
        case (state)
            IDLE: begin
                if (req0_arvalid || req1_arvalid) begin
                    // On a tie the requester that did not win last time goes first.
                    pick           = (req0_arvalid && req1_arvalid) ? ~last_grant : req1_arvalid;
                    arready0_nx    = ~pick;
                    arready1_nx    = pick;
                    mem_arvalid_nx = 1'b1;
                    mem_addr_nx    = pick ? req1_addr : req0_addr;
                    gnt_id_nx      = pick;
                    last_grant_nx  = pick;
                    cnt_nx         = '0;
                    state_nx       = BUSY;
                end
            end
            BUSY: begin
                if (mem_rvalid) begin
                    rsp_data_nx    = mem_data;
                    rvalid0_nx     = ~gnt_id;
                    rvalid1_nx     = gnt_id;
                    mem_arvalid_nx = 1'b0;
                    state_nx       = RESP;
                end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
                    rsp_data_nx    = '0;
                    rvalid0_nx     = ~gnt_id;
                    rvalid1_nx     = gnt_id;
                    err0_nx        = ~gnt_id;
                    err1_nx        = gnt_id;
                    mem_arvalid_nx = 1'b0;
                    state_nx       = RESP;
                end else if (cnt != {CNT_W{1'b1}}) begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            cnt          <= '0;
            req0_arready <= 1'b0;
            req1_arready <= 1'b0;
            req0_rvalid  <= 1'b0;
            req1_rvalid  <= 1'b0;
            req0_err     <= 1'b0;
            req1_err     <= 1'b0;
            rsp_data     <= '0;
            mem_arvalid  <= 1'b0;
            mem_addr     <= '0;
            gnt_id       <= 1'b0;
        end else begin
            state        <= state_nx;
            last_grant   <= last_grant_nx;
            cnt          <= cnt_nx;
            req0_arready <= arready0_nx;
            req1_arready <= arready1_nx;
            req0_rvalid  <= rvalid0_nx;
            req1_rvalid  <= rvalid1_nx;
            req0_err     <= err0_nx;
            req1_err     <= err1_nx;
            rsp_data     <= rsp_data_nx;
            mem_arvalid  <= mem_arvalid_nx;
            mem_addr     <= mem_addr_nx;
            gnt_id       <= gnt_id_nx;
        end
    end
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed scenarios plus randomized traffic scored
// against a transaction-level round-robin/watchdog model.
module tb_mem_read_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_arvalid, req1_arvalid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic              req0_arready, req0_rvalid, req0_err;
    logic              req1_arready, req1_rvalid, req1_err;
    logic [DATA_W-1:0] rsp_data;
    logic              mem_arvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_rvalid;
    logic              gnt_id;
    logic [1:0]        dbg_state;

    int vectors = 0;
    int miscompares = 0;

    // Model state: who won last, who is waiting, and the expected response lines.
    logic              model_last;
    logic              pend0, pend1;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] last_rsp;
    logic [DATA_W-1:0] exp_q[$];

    mem_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_arvalid(req0_arvalid), .req0_addr(req0_addr), .req0_arready(req0_arready),
        .req0_rvalid(req0_rvalid), .req0_err(req0_err),
        .req1_arvalid(req1_arvalid), .req1_addr(req1_addr), .req1_arready(req1_arready),
        .req1_rvalid(req1_rvalid), .req1_err(req1_err),
        .rsp_data(rsp_data), .mem_arvalid(mem_arvalid), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_rvalid(mem_rvalid), .gnt_id(gnt_id), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic apply_reset();
        rst_n = 1'b1;
        req0_arvalid = 1'b0; req1_arvalid = 1'b0;
        req0_addr = '0; req1_addr = '0;
        mem_rvalid = 1'b0; mem_data = '0;
        pend0 = 1'b0; pend1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_last = 1'b1;
        last_rsp = '0;
        exp_q.delete();
    endtask

    // Entry: just after an edge with the DUT idle; pend0/pend1/a0/a1 describe the requests.
    // lat = BUSY cycle index in which memory answers; lat >= TIMEOUT means it never does.
    task automatic do_txn(input int lat, input logic [DATA_W-1:0] d, input bit keep, input bit glitch);
        logic              w, exp_err;
        logic [ADDR_W-1:0] exp_a;
        logic [DATA_W-1:0] exp_d;
        req0_arvalid = pend0; req1_arvalid = pend1;
        req0_addr = a0; req1_addr = a1;
        w = (pend0 && pend1) ? ~model_last : pend1;
        model_last = w;
        exp_a = w ? a1 : a0;
        exp_err = (lat > TIMEOUT - 1);
        exp_q.push_back(exp_err ? '0 : d);
        @(posedge clk); #1;
        vectors++;
        if ({req0_arready, req1_arready, mem_arvalid, gnt_id, mem_addr} !== {~w, w, 1'b1, w, exp_a}) begin
            miscompares++;
            $display("FAIL grant: got ardy0/ardy1/arv/gnt/addr=%b%b%b%b/%h want %b%b%b%b/%h",
                     req0_arready, req1_arready, mem_arvalid, gnt_id, mem_addr, ~w, w, 1'b1, w, exp_a);
        end
        if (!keep) begin
            if (w) pend1 = 1'b0; else pend0 = 1'b0;
        end
        req0_arvalid = pend0; req1_arvalid = pend1;
        for (int k = 0; k < TIMEOUT; k++) begin
            mem_rvalid = (k == lat);
            mem_data   = (k == lat) ? d : {$urandom, $urandom};
            if (glitch && !pend0) req0_arvalid = (k == 1);
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            req0_arvalid = pend0;
            if (k == lat || k == TIMEOUT - 1) break;
            vectors++;
            if ({req0_arready, req1_arready, req0_rvalid, req1_rvalid, mem_arvalid, mem_addr} !==
                {5'b00001, exp_a}) begin
                miscompares++;
                $display("FAIL busy_hold k=%0d: got ardy/rv/arv=%b%b%b%b%b addr=%h want 00001 addr=%h",
                         k, req0_arready, req1_arready, req0_rvalid, req1_rvalid, mem_arvalid, mem_addr, exp_a);
            end
        end
        exp_d = exp_q.pop_front();
        last_rsp = exp_d;
        vectors++;
        if ({req0_rvalid, req1_rvalid, req0_err, req1_err, mem_arvalid, rsp_data} !==
            {~w, w, ~w & exp_err, w & exp_err, 1'b0, exp_d}) begin
            miscompares++;
            $display("FAIL response: got rv0/rv1/err0/err1/arv=%b%b%b%b%b data=%h want %b%b%b%b0 data=%h",
                     req0_rvalid, req1_rvalid, req0_err, req1_err, mem_arvalid, rsp_data,
                     ~w, w, ~w & exp_err, w & exp_err, exp_d);
        end
        @(posedge clk); #1;
        vectors++;
        if ({req0_arready, req1_arready, req0_rvalid, req1_rvalid, req0_err, req1_err, mem_arvalid, rsp_data} !==
            {7'b0, exp_d}) begin
            miscompares++;
            $display("FAIL resp_gap: got flags=%b%b%b%b%b%b%b data=%h want 0000000 data=%h",
                     req0_arready, req1_arready, req0_rvalid, req1_rvalid, req0_err, req1_err,
                     mem_arvalid, rsp_data, exp_d);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if ({req0_arready, req0_rvalid, req0_err, req1_arready, req1_rvalid, req1_err,
             mem_arvalid, gnt_id, mem_addr, rsp_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got flags=%b%b%b%b%b%b%b%b addr=%h data=%h want all 0",
                     req0_arready, req0_rvalid, req0_err, req1_arready, req1_rvalid, req1_err,
                     mem_arvalid, gnt_id, mem_addr, rsp_data);
        end
    endtask

    task automatic test_single_read();
        pend0 = 1'b1; a0 = 32'h0000_0040;
        do_txn(1, 64'h1122_3344_5566_7788, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        pend0 = 1'b1; pend1 = 1'b1; a0 = 32'h100; a1 = 32'h200;
        repeat (4) do_txn(0, {$urandom, $urandom}, 1'b1, 1'b0);
        pend0 = 1'b0; pend1 = 1'b0;
    endtask

    task automatic test_timeout();
        pend1 = 1'b1; a1 = 32'h0000_1230;
        do_txn(99, 64'h0, 1'b0, 1'b0);
        pend0 = 1'b1; a0 = 32'h0000_4560;
        do_txn(2, 64'hCAFE_F00D_1234_5678, 1'b0, 1'b0);
        pend0 = 1'b1; a0 = 32'h0000_0008;
        do_txn(TIMEOUT - 1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0);
    endtask

    task automatic test_spurious_and_withdraw();
        req0_arvalid = 1'b0; req1_arvalid = 1'b0;
        mem_rvalid = 1'b1; mem_data = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        vectors++;
        if ({req0_arready, req1_arready, req0_rvalid, req1_rvalid, mem_arvalid, rsp_data} !==
            {5'b0, last_rsp}) begin
            miscompares++;
            $display("FAIL spurious_rvalid: got flags=%b%b%b%b%b data=%h want 00000 data=%h",
                     req0_arready, req1_arready, req0_rvalid, req1_rvalid, mem_arvalid, rsp_data, last_rsp);
        end
        pend1 = 1'b1; a1 = 32'h0000_0A00;
        do_txn(3, {$urandom, $urandom}, 1'b0, 1'b1);
        repeat (2) begin
            @(posedge clk); #1;
            vectors++;
            if ({req0_arready, req1_arready, mem_arvalid} !== 3'b000) begin
                miscompares++;
                $display("FAIL withdrawn_request: got ardy0/ardy1/arv=%b%b%b want 000",
                         req0_arready, req1_arready, mem_arvalid);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        req0_arvalid = 1'b1; req0_addr = 32'h0000_0080;
        @(posedge clk); #1;
        req0_arvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        model_last = 1'b1;
        vectors++;
        if ({req0_arready, req0_rvalid, req0_err, req1_arready, req1_rvalid, req1_err,
             mem_arvalid, gnt_id, mem_addr, rsp_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_busy: got flags=%b%b%b%b%b%b%b%b addr=%h data=%h want all 0",
                     req0_arready, req0_rvalid, req0_err, req1_arready, req1_rvalid, req1_err,
                     mem_arvalid, gnt_id, mem_addr, rsp_data);
        end
        mem_rvalid = 1'b1; mem_data = 64'h5555_AAAA_5555_AAAA;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        vectors++;
        if ({req0_rvalid, req1_rvalid, mem_arvalid, rsp_data} !== {3'b000, 64'h0}) begin
            miscompares++;
            $display("FAIL late_rvalid: got rv0/rv1/arv=%b%b%b data=%h want 000 data=0",
                     req0_rvalid, req1_rvalid, mem_arvalid, rsp_data);
        end
        last_rsp = '0;
        pend0 = 1'b1; pend1 = 1'b1; a0 = 32'h0000_0080; a1 = 32'h0000_0C00;
        do_txn(0, {$urandom, $urandom}, 1'b0, 1'b0);
        do_txn(1, {$urandom, $urandom}, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if (!pend0) begin
                pend0 = 1'($urandom_range(0, 1));
                a0 = $urandom & 32'hFFFF_FFF8;
            end
            if (!pend1) begin
                pend1 = 1'($urandom_range(0, 1));
                a1 = $urandom & 32'hFFFF_FFF8;
            end
            if (!pend0 && !pend1) pend0 = 1'b1;
            do_txn($urandom_range(0, TIMEOUT + 1), {$urandom, $urandom}, 1'b0, 1'b0);
        end
        pend0 = 1'b0; pend1 = 1'b0;
        req0_arvalid = 1'b0; req1_arvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_timeout();
        test_spurious_and_withdraw();
        test_reset_mid_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
